tmds_channel_decoder: RTL and testbench

//  Receive-side counterpart of the per-channel TMDS encoder in our DVI output path.
//  - Input: unaligned 10-bit words from a 1:10 deserializer.
//  - Finds symbol alignment by hunting for runs of TMDS control tokens.
//  - Decodes 8-bit pixel data, the 2 control bits and DE (inverse of blank).
//  - One instance per channel (R/G/B). Output feeds DVI-capture / loopback self-test logic.

---
 rtl/tmds_channel_decoder.sv | 185 ++++++++++++++++++
 tb/tb_tmds_channel_decoder.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tmds_channel_decoder.sv
// rtl/tmds_channel_decoder.sv - TMDS per-channel word aligner and symbol decoder
module tmds_channel_decoder #(
  parameter int C_LOCK_RUN     = 8,
  parameter int C_SEARCH_WORDS = 2048,
  parameter int C_LOSS_WORDS   = 4096,
  parameter int C_depth        = 8
) (
  input  logic               clk_pixel,
  input  logic               reset_n,
  input  logic [9:0]         in_word,
  input  logic               in_valid,
  output logic               out_valid,
  output logic [C_depth-1:0] out_data,
  output logic [1:0]         out_c,
  output logic               out_de,
  output logic               out_locked,
  output logic [3:0]         out_offset
);

  localparam int RUN_W    = (C_LOCK_RUN > 1) ? $clog2(C_LOCK_RUN) : 1;
  localparam int SEARCH_W = (C_SEARCH_WORDS > 1) ? $clog2(C_SEARCH_WORDS) : 1;
  localparam int LOSS_W   = (C_LOSS_WORDS > 1) ? $clog2(C_LOSS_WORDS) : 1;

  localparam logic [RUN_W-1:0]    RUN_LAST    = RUN_W'(C_LOCK_RUN - 1);
  localparam logic [SEARCH_W-1:0] SEARCH_LAST = SEARCH_W'(C_SEARCH_WORDS - 1);
  localparam logic [LOSS_W-1:0]   LOSS_LAST   = LOSS_W'(C_LOSS_WORDS - 1);

  typedef enum logic {
    S_SEARCH = 1'b0,
    S_LOCKED = 1'b1
  } state_t;

  // Stage 1 registers
  logic [9:0]  prev_word;
  logic [9:0]  sym;
  logic        sym_v;
  logic [19:0] window;
  logic [9:0]  window_slice;

  // Alignment FSM state
  state_t              state, state_next;
  logic [RUN_W-1:0]    run, run_next;
  logic [SEARCH_W-1:0] search_cnt, search_next;
  logic [LOSS_W-1:0]   loss_cnt, loss_next;
  logic [3:0]          offset, offset_next;

  // Symbol classification and decode
  logic       is_token;
  logic [1:0] tok_c;
  logic [7:0] q;
  logic [7:0] dec;

  // Two consecutive words cover every possible 10-bit alignment.
  assign window       = {in_word, prev_word};
  assign window_slice = 10'(window >> offset);

  // Stage 1: capture the symbol at the current bit offset
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      prev_word <= '0;
      sym       <= '0;
      sym_v     <= 1'b0;
    end else begin
      sym_v <= in_valid;
      if (in_valid) begin
        prev_word <= in_word;
        sym       <= window_slice;
      end
    end
  end

  // Recognise the four control tokens
  always_comb begin
    is_token = 1'b1;
    tok_c    = 2'b00;
    case (sym)
      10'h354: tok_c = 2'b00;
      10'h0AB: tok_c = 2'b01;
      10'h154: tok_c = 2'b10;
      10'h2AB: tok_c = 2'b11;
      default: is_token = 1'b0;
    endcase
  end

  // Undo the TMDS inversion and XOR/XNOR chaining
  always_comb begin
    q      = sym[9] ? ~sym[7:0] : sym[7:0];
    dec    = '0;
    dec[0] = q[0];
    for (int i = 1; i < 8; i++) begin
      dec[i] = sym[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    end
  end

  // Alignment FSM state register
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_SEARCH;
      run        <= '0;
      search_cnt <= '0;
      loss_cnt   <= '0;
      offset     <= '0;
    end else begin
      state      <= state_next;
      run        <= run_next;
      search_cnt <= search_next;
      loss_cnt   <= loss_next;
      offset     <= offset_next;
    end
  end

  // Alignment FSM next state: hunt offsets for token runs, drop lock on silence
  always_comb begin
    state_next  = state;
    run_next    = run;
    search_next = search_cnt;
    loss_next   = loss_cnt;
    offset_next = offset;
    if (sym_v) begin
      case (state)
        S_SEARCH: begin
          if (is_token && (run == RUN_LAST)) begin
            // Lock beats a coincident timeout so the good offset is kept.
            state_next  = S_LOCKED;
            loss_next   = '0;
            run_next    = '0;
            search_next = '0;
          end else begin
            run_next = is_token ? run + 1'b1 : '0;
            if (search_cnt == SEARCH_LAST) begin
              offset_next = (offset == 4'd9) ? 4'd0 : offset + 4'd1;
              run_next    = '0;
              search_next = '0;
            end else begin
              search_next = search_cnt + 1'b1;
            end
          end
        end
        S_LOCKED: begin
          if (is_token) begin
            loss_next = '0;
          end else if (loss_cnt == LOSS_LAST) begin
            state_next  = S_SEARCH;
            run_next    = '0;
            search_next = '0;
          end else begin
            loss_next = loss_cnt + 1'b1;
          end
        end
        default: state_next = S_SEARCH;
      endcase
    end
  end

  // Output stage: reflects the lock state resulting from this symbol
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_c     <= 2'b00;
      out_de    <= 1'b0;
    end else begin
      out_valid <= sym_v;
      if (sym_v) begin
        if (state_next == S_LOCKED) begin
          if (is_token) begin
            out_de <= 1'b0;
            out_c  <= tok_c;
          end else begin
            out_de   <= 1'b1;
            out_data <= dec[7 -: C_depth];
          end
        end else begin
          out_de   <= 1'b0;
          out_c    <= 2'b00;
          out_data <= '0;
        end
      end
    end
  end

  assign out_locked = (state == S_LOCKED);
  assign out_offset = offset;

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// tb/tb_tmds_channel_decoder.sv - scoreboard bench for tmds_channel_decoder
module tb_tmds_channel_decoder;

  localparam int LOCK_RUN     = 8;
  localparam int SEARCH_WORDS = 2048;
  localparam int LOSS_WORDS   = 4096;
  localparam int DEPTH        = 8;

  logic             clk_pixel = 1'b0;
  logic             reset_n   = 1'b0;
  logic [9:0]       in_word   = '0;
  logic             in_valid  = 1'b0;
  logic             out_valid;
  logic [DEPTH-1:0] out_data;
  logic [1:0]       out_c;
  logic             out_de;
  logic             out_locked;
  logic [3:0]       out_offset;

  tmds_channel_decoder #(
    .C_LOCK_RUN    (LOCK_RUN),
    .C_SEARCH_WORDS(SEARCH_WORDS),
    .C_LOSS_WORDS  (LOSS_WORDS),
    .C_depth       (DEPTH)
  ) dut (
    .clk_pixel (clk_pixel),
    .reset_n   (reset_n),
    .in_word   (in_word),
    .in_valid  (in_valid),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_c     (out_c),
    .out_de    (out_de),
    .out_locked(out_locked),
    .out_offset(out_offset)
  );

  always #5 clk_pixel = ~clk_pixel;

  typedef struct {
    bit         valid;
    logic [7:0] data;
    logic [1:0] c;
    bit         de;
    bit         locked;
    int         offset;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  logic [9:0] tokens [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};

  // Reference model state
  logic [9:0] m_prev;
  logic [9:0] m_pend;
  bit         m_pend_v;
  bit         m_locked;
  int         m_run, m_search, m_loss, m_offset;
  logic [7:0] m_data;
  logic [1:0] m_c;
  bit         m_de;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit tok_of(input logic [9:0] s, output logic [1:0] c);
    c = 2'b00;
    for (int k = 0; k < 4; k++) begin
      if (s == tokens[k]) begin
        c = (k == 0) ? 2'b00 : (k == 1) ? 2'b01 : (k == 2) ? 2'b10 : 2'b11;
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  function automatic logic [7:0] tmds_decode(input logic [9:0] s);
    logic [7:0] qq, x;
    qq = s[9] ? ~s[7:0] : s[7:0];
    x  = qq ^ {qq[6:0], 1'b0};
    return s[8] ? x : (x ^ 8'hFE);
  endfunction

  task automatic model_reset();
    m_prev = '0; m_pend = '0; m_pend_v = 1'b0; m_locked = 1'b0;
    m_run = 0; m_search = 0; m_loss = 0; m_offset = 0;
    m_data = '0; m_c = '0; m_de = 1'b0;
  endtask

  task automatic model_step(input bit v, input logic [9:0] w);
    exp_t       e;
    logic [9:0] ns;
    logic [1:0] tc;
    bit         tok;
    int         pair;
    ns = '0;
    if (v) begin
      pair   = (int'(w) * 1024) + int'(m_prev);
      ns     = 10'((pair >> m_offset) % 1024);
      m_prev = w;
    end
    e.valid = m_pend_v;
    if (m_pend_v) begin
      tok = tok_of(m_pend, tc);
      if (!m_locked) begin
        m_search++;
        m_run = tok ? m_run + 1 : 0;
        if (m_run >= LOCK_RUN) begin
          m_locked = 1'b1;
          m_loss   = 0;
        end else if (m_search == SEARCH_WORDS) begin
          m_offset = (m_offset + 1) % 10;
          m_run    = 0;
          m_search = 0;
        end
      end else if (tok) begin
        m_loss = 0;
      end else begin
        m_loss++;
        if (m_loss == LOSS_WORDS) begin
          m_locked = 1'b0;
          m_run    = 0;
          m_search = 0;
        end
      end
      if (m_locked) begin
        if (tok) begin
          m_de = 1'b0;
          m_c  = tc;
        end else begin
          m_de   = 1'b1;
          m_data = tmds_decode(m_pend) >> (8 - DEPTH);
        end
      end else begin
        m_de = 1'b0; m_c = 2'b00; m_data = '0;
      end
    end
    e.data = m_data; e.c = m_c; e.de = m_de; e.locked = m_locked; e.offset = m_offset;
    sb.push_back(e);
    m_pend_v = v;
    if (v) m_pend = ns;
  endtask

  // Monitor: one expectation per clock edge since reset release
  always @(negedge clk_pixel) begin
    exp_t e;
    if (reset_n && sb.size() > 0) begin
      e = sb.pop_front();
      chk("out_valid", 32'(out_valid), 32'(e.valid));
      if (e.valid) begin
        chk("out_locked", 32'(out_locked), 32'(e.locked));
        chk("out_offset", 32'(out_offset), 32'(e.offset));
        chk("out_de", 32'(out_de), 32'(e.de));
        chk("out_c", 32'(out_c), 32'(e.c));
        chk("out_data", 32'(out_data), 32'(e.data));
      end
    end
  end

  task automatic cyc(input bit v, input logic [9:0] w);
    in_valid = v;
    in_word  = w;
    @(posedge clk_pixel);
    #1;
    if (reset_n) model_step(v, w);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_c", 32'(out_c), 0);
    chk("rst_de", 32'(out_de), 0);
    chk("rst_locked", 32'(out_locked), 0);
    chk("rst_offset", 32'(out_offset), 0);
    sb.delete();
    model_reset();
    repeat (2) @(posedge clk_pixel);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic aligned_seq(input bit gap);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 10'h354);
      if (gap && i == 3) begin
        for (int g = 0; g < 10; g++) begin
          cyc(1'b0, 10'($urandom));
          if (g >= 1) chk("gap_valid", 32'(out_valid), 0);
          chk("gap_locked", 32'(out_locked), 0);
        end
      end
    end
    chk("lock_t0", 32'(out_locked), 0);
    cyc(1'b1, 10'h100);
    chk("lock_t1", 32'(out_locked), 0);
    cyc(1'b1, 10'h3FF);
    chk("lock_t2", 32'(out_locked), 1);
    cyc(1'b1, 10'h0FF);
    chk("dec_100_de", 32'(out_de), 1);
    chk("dec_100", 32'(out_data), 32'h00);
    cyc(1'b1, 10'h354);
    chk("dec_3ff", 32'(out_data), 32'h00);
    cyc(1'b1, 10'h354);
    chk("dec_0ff", 32'(out_data), 32'hFF);
    chk("dec_0ff_de", 32'(out_de), 1);
    chk("dec_0ff_c", 32'(out_c), 0);
  endtask

  logic [2:0] gen_carry;
  int         off_changes;
  logic [3:0] last_off;
  bit         got_lock;

  task automatic gen_word(input logic [9:0] s);
    logic [9:0] w;
    w         = {s[6:0], gen_carry};
    gen_carry = s[9:7];
    cyc(1'b1, w);
    if (out_offset != last_off) begin
      off_changes++;
      last_off = out_offset;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired actual=running expected=finished");
    $fatal(1);
  end

  initial begin
    logic [9:0] w;
    bit         v;
    model_reset();
    do_reset();

    // Aligned lock and decode, then token controls
    aligned_seq(1'b0);
    cyc(1'b1, 10'h2AB);
    cyc(1'b1, 10'h0AB);
    cyc(1'b1, 10'h154);
    chk("ctl_11", 32'(out_c), 32'h3);
    chk("ctl_11_de", 32'(out_de), 0);
    cyc(1'b1, 10'h100);
    chk("ctl_01", 32'(out_c), 32'h1);
    cyc(1'b1, 10'h100);
    chk("ctl_10", 32'(out_c), 32'h2);

    // Random mix of tokens, data and stalls
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 3) == 0) w = tokens[$urandom_range(0, 3)];
      else w = 10'($urandom);
      cyc(v, w);
    end

    // Reset mid-stream with in_valid high
    in_valid = 1'b1;
    do_reset();

    // Aligned lock with a 10-cycle stall
    aligned_seq(1'b1);

    // Loss of lock after 4096 non-token words
    do_reset();
    for (int i = 0; i <= 4105; i++) begin
      cyc(1'b1, (i < 8) ? 10'h354 : 10'h100);
      if (i == 4104) chk("loss_before", 32'(out_locked), 1);
      if (i == 4105) chk("loss_at", 32'(out_locked), 0);
    end
    chk("loss_offset", 32'(out_offset), 0);

    // Serial stream delayed by 3 bits, 800-word lines
    do_reset();
    gen_carry   = 3'b000;
    off_changes = 0;
    last_off    = 4'd0;
    got_lock    = 1'b0;
    for (int n = 0; n < 9000 && !got_lock; n++) begin
      gen_word(((n % 800) < 160) ? 10'h354 : 10'($urandom));
      if (out_locked) got_lock = 1'b1;
    end
    chk("shift_locked", 32'(got_lock), 1);
    chk("shift_offset", 32'(out_offset), 3);
    chk("shift_timeouts", 32'(off_changes), 3);
    gen_word(10'h100);
    gen_word(10'h3FF);
    gen_word(10'h0FF);
    for (int n = 0; n < 4110; n++) gen_word(10'h100);
    chk("shift_loss", 32'(out_locked), 0);
    chk("shift_loss_offset", 32'(out_offset), 3);

    cyc(1'b0, 10'h000);
    cyc(1'b0, 10'h000);
    @(negedge clk_pixel);
    #1;
    chk("sb_drained", 32'(sb.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
